stream_mux_nx1: RTL

- Parametrised successor to the datapath 2:1 mux: N-input, DATAWIDTH-wide selector with valid/ready handshakes on every input and the output.
- Adds one registered output stage and a runtime mode: explicit-select or round-robin arbitration.
- Sits between datapath producers (REG/ALU stage outputs) and a shared consumer, e.g. a shared functional unit or writeback bus.
- One transfer per cycle sustained; latency 1 cycle.

---
 rtl/datapath_pkg.sv | 33 +++
 rtl/stream_mux_nx1_rr_pick.sv | 31 +++
 rtl/stream_mux_nx1.sv | 139 +++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: mode encodings and select-width derivation
// used by the stream multiplexer and its rotating priority finder.
package datapath_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Ceiling log2 of a positive integer; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // Channel-index width: never narrower than one bit.
  function automatic int sel_width(input int num_inputs);
    int w;
    w = clog2(num_inputs);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_mux_nx1_rr_pick.sv
// Rotating priority finder: searches the request vector starting one slot
// past ptr (wrapping modulo N) and reports the first requester found.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          grant_valid,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] cand_s;

  // First requesting channel after ptr in circular order.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_s      = '0;
    for (int k = 1; k <= N; k++) begin
      cand_s = PW'((int'(ptr) + k) % N);
      if (!grant_valid && req[cand_s]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_s;
      end else begin
        grant_idx   = grant_idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-input valid/ready stream multiplexer with one registered output stage.
// Grant comes from either an explicit channel select or a round-robin
// search that resumes after the most recently served channel.
module stream_mux_nx1
  import datapath_pkg::*;
#(
  parameter  int DATAWIDTH  = 8,
  parameter  int NUM_INPUTS = 4,
  localparam int SELW       = sel_width(NUM_INPUTS)
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [NUM_INPUTS*DATAWIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]           in_valid,
  output logic [NUM_INPUTS-1:0]           in_ready,
  input  logic                            mode,
  input  logic [SELW-1:0]                 sel,
  output logic [DATAWIDTH-1:0]            out_data,
  output logic [SELW-1:0]                 out_src,
  output logic                            out_valid,
  input  logic                            out_ready
);

  logic [DATAWIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]      out_src_q, out_src_d;
  logic                 out_valid_q, out_valid_d;
  logic [SELW-1:0]      ptr_q, ptr_d;

  logic                 rr_valid_s;
  logic [SELW-1:0]      rr_idx_s;
  logic                 sel_valid_s;
  logic                 grant_valid_s;
  logic [SELW-1:0]      grant_idx_s;
  logic                 load_s;
  logic [DATAWIDTH-1:0] grant_data_s;

  rr_pick #(
    .N  (NUM_INPUTS),
    .PW (SELW)
  ) u_rr_pick (
    .req         (in_valid),
    .ptr         (ptr_q),
    .grant_valid (rr_valid_s),
    .grant_idx   (rr_idx_s)
  );

  // Explicit-select request: an out-of-range sel matches no channel.
  always_comb begin
    sel_valid_s = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (sel == SELW'(i)) begin
        sel_valid_s = in_valid[i];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Grant choice by mode, and the load condition that allows pass-through
  // when the held word leaves in the same cycle.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    case (mode)
      MODE_SEL: begin
        grant_valid_s = sel_valid_s;
        grant_idx_s   = sel;
      end
      MODE_RR: begin
        grant_valid_s = rr_valid_s;
        grant_idx_s   = rr_idx_s;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
      end
    endcase
    load_s = !Rst && grant_valid_s && (!out_valid_q || out_ready);
  end

  // One-hot ready toward the granted producer; depends only on control.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i] = load_s && (grant_idx_s == SELW'(i));
    end
  end

  // Data path mux for the granted channel.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx_s == SELW'(i)) begin
        grant_data_s = in_data[i*DATAWIDTH +: DATAWIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Next output-stage state: load, drain on consume, or hold under stall.
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_s) begin
      out_data_d  = grant_data_s;
      out_src_d   = grant_idx_s;
      out_valid_d = 1'b1;
      ptr_d       = grant_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register and round-robin pointer; reset points ptr at the last
  // channel so the first round-robin grant goes to channel 0.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(NUM_INPUTS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule
